// File: rtl/traffic_pkg.sv
// Shared types and constants for the intersection phase controller.
// State codes, lamp encodings, default timing and the lamp decoder.
package traffic_pkg;

  typedef enum logic [2:0] {
    ALLRED_A  = 3'd0,
    NS_GREEN  = 3'd1,
    NS_YELLOW = 3'd2,
    ALLRED_B  = 3'd3,
    EW_GREEN  = 3'd4,
    EW_YELLOW = 3'd5
  } state_t;

  localparam logic [2:0] LIGHT_RED = 3'b100;
  localparam logic [2:0] LIGHT_YEL = 3'b010;
  localparam logic [2:0] LIGHT_GRN = 3'b001;

  localparam int DEF_T_GREEN     = 20;
  localparam int DEF_T_GREEN_MIN = 8;
  localparam int DEF_T_YELLOW    = 3;
  localparam int DEF_T_ALLRED    = 1;
  localparam int DEF_TW          = 8;

  typedef struct packed {
    logic [2:0] ns;
    logic [2:0] ew;
    logic       walk_ns;
    logic       walk_ew;
  } lamps_t;

  // Unknown codes decode to all-red so the pins stay safe.
  function automatic lamps_t decode_lamps(state_t s);
    lamps_t l;
    l = '{ns: LIGHT_RED, ew: LIGHT_RED,
          walk_ns: 1'b0, walk_ew: 1'b0};
    case (s)
      NS_GREEN: begin
        l.ns      = LIGHT_GRN;
        l.walk_ns = 1'b1;
      end
      NS_YELLOW: l.ns = LIGHT_YEL;
      EW_GREEN: begin
        l.ew      = LIGHT_GRN;
        l.walk_ew = 1'b1;
      end
      EW_YELLOW: l.ew = LIGHT_YEL;
      default: ;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/traffic_phase_controller_timer.sv
// phase_timer: TW-bit tick counter with clear and terminal compare.
// Ports: clk_in, rst, clr, tick, dur in; expired (count==dur-1), count out.
module phase_timer #(
  parameter int TW = 8
) (
  input  logic          clk_in,
  input  logic          rst,
  input  logic          clr,
  input  logic          tick,
  input  logic [TW-1:0] dur,
  output logic          expired,
  output logic [TW-1:0] count
);

  assign expired = (count == dur - TW'(1));

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (tick) begin
      count <= expired ? '0 : count + TW'(1);
    end
  end

endmodule

// File: rtl/traffic_phase_controller.sv
// Two-way intersection phase FSM: lamps, walk lamps, ped-request latches.
// Ports: clk_in, rst, tick, ped_req_ns/ew [, preempt if PREEMPT_EN] in;
//   ns_light, ew_light, walk_ns/ew, phase, pend_ns/ew out.
module traffic_phase_controller
  import traffic_pkg::*;
#(
  parameter int T_GREEN     = DEF_T_GREEN,
  parameter int T_GREEN_MIN = DEF_T_GREEN_MIN,
  parameter int T_YELLOW    = DEF_T_YELLOW,
  parameter int T_ALLRED    = DEF_T_ALLRED,
  parameter int TW          = DEF_TW
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       tick,
`ifdef PREEMPT_EN
  input  logic       preempt,
`endif
  input  logic       ped_req_ns,
  input  logic       ped_req_ew,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       walk_ns,
  output logic       walk_ew,
  output logic [2:0] phase,
  output logic       pend_ns,
  output logic       pend_ew
);

  state_t        state_q;
  state_t        state_d;
  logic [TW-1:0] dur;
  logic [TW-1:0] count;
  logic          expired;
  logic          hold;
  logic          tmr_clr;
  logic          min_done;
  lamps_t        lamps;

  assign min_done = (count >= TW'(T_GREEN_MIN - 1));

  always_comb begin
    state_d = state_q;
    dur     = TW'(T_ALLRED);
    hold    = 1'b0;
    unique case (state_q)
      ALLRED_A: begin
        if (tick && expired) state_d = NS_GREEN;
      end
      NS_GREEN: begin
        dur = TW'(T_GREEN);
        if (tick && (expired || (pend_ew && min_done)))
          state_d = NS_YELLOW;
      end
      NS_YELLOW: begin
        dur = TW'(T_YELLOW);
        if (tick && expired) state_d = ALLRED_B;
      end
      ALLRED_B: begin
        if (tick && expired) state_d = EW_GREEN;
      end
      EW_GREEN: begin
        dur = TW'(T_GREEN);
        if (tick && (expired || (pend_ns && min_done)))
          state_d = EW_YELLOW;
      end
      EW_YELLOW: begin
        dur = TW'(T_YELLOW);
        if (tick && expired) state_d = ALLRED_A;
      end
      default: state_d = ALLRED_A;
    endcase
`ifdef PREEMPT_EN
    // Greens drop at once; all-red parks with the timer pinned at 0.
    if (preempt) begin
      unique case (state_q)
        NS_GREEN: state_d = NS_YELLOW;
        EW_GREEN: state_d = EW_YELLOW;
        ALLRED_A, ALLRED_B: begin
          state_d = state_q;
          hold    = 1'b1;
        end
        default: ;
      endcase
    end
`endif
  end

  // Any state change restarts the phase timer.
  assign tmr_clr = (state_d != state_q) || hold;

  phase_timer #(.TW(TW)) u_timer (
    .clk_in  (clk_in),
    .rst     (rst),
    .clr     (tmr_clr),
    .tick    (tick),
    .dur     (dur),
    .expired (expired),
    .count   (count)
  );

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q <= ALLRED_A;
    end else begin
      state_q <= state_d;
    end
  end

  // Entry into the served green wins over a same-cycle request.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      pend_ns <= 1'b0;
      pend_ew <= 1'b0;
    end else begin
      if (state_d == NS_GREEN && state_q != NS_GREEN)
        pend_ns <= 1'b0;
      else if (ped_req_ns && state_q != NS_GREEN)
        pend_ns <= 1'b1;
      if (state_d == EW_GREEN && state_q != EW_GREEN)
        pend_ew <= 1'b0;
      else if (ped_req_ew && state_q != EW_GREEN)
        pend_ew <= 1'b1;
    end
  end

  assign lamps    = decode_lamps(state_q);
  assign ns_light = lamps.ns;
  assign ew_light = lamps.ew;
  assign walk_ns  = lamps.walk_ns;
  assign walk_ew  = lamps.walk_ew;
  assign phase    = state_q;

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Directed bench for traffic_phase_controller.
// Short timing, tick every 4 clocks; PREEMPT_EN adds the preempt scenario.
module tb_traffic_phase_controller;
  import traffic_pkg::*;

  logic clk_in = 1'b0;
  logic rst;
  logic tick;
  logic ped_req_ns;
  logic ped_req_ew;
`ifdef PREEMPT_EN
  logic preempt;
`endif
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic [2:0] phase;
  logic walk_ns;
  logic walk_ew;
  logic pend_ns;
  logic pend_ew;

  bit tick_en;
  logic [1:0] tcnt;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk_in = ~clk_in;

  traffic_phase_controller #(
    .T_GREEN(5), .T_GREEN_MIN(2), .T_YELLOW(2),
    .T_ALLRED(1), .TW(8)
  ) dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .tick       (tick),
`ifdef PREEMPT_EN
    .preempt    (preempt),
`endif
    .ped_req_ns (ped_req_ns),
    .ped_req_ew (ped_req_ew),
    .ns_light   (ns_light),
    .ew_light   (ew_light),
    .walk_ns    (walk_ns),
    .walk_ew    (walk_ew),
    .phase      (phase),
    .pend_ns    (pend_ns),
    .pend_ew    (pend_ew)
  );

  // One clock: tick on every 4th cycle, outputs sampled 1 after edge.
  task automatic cyc();
    tick = tick_en && (tcnt == 2'd3);
    tcnt = tcnt + 2'd1;
    @(posedge clk_in);
    #1;
  endtask

  task automatic run_to(input logic [2:0] p, input string tag);
    int g;
    g = 0;
    while (phase !== p && g < 200) begin
      cyc();
      g++;
    end
    n_checks++;
    if (phase !== p) begin
      n_fail++;
      $display("FAIL %s: phase %0d want %0d", tag, phase, p);
    end
  endtask

  // Ticks consumed until the phase changes (bounded).
  task automatic dwell(output int n);
    logic [2:0] p0;
    int g;
    p0 = phase;
    n = 0;
    g = 0;
    while (phase === p0 && g < 400) begin
      cyc();
      g++;
      if (tick) n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick = 1'b0;
    ped_req_ns = 1'b0;
    ped_req_ew = 1'b0;
`ifdef PREEMPT_EN
    preempt = 1'b0;
`endif
    tick_en = 1'b1;
    tcnt = 2'd0;
    repeat (3) @(posedge clk_in);
    #1;
    n_checks++;
    if ({ns_light, ew_light} !== 6'b100_100) begin
      n_fail++;
      $display("FAIL rst_lights: %b %b want 100 100",
               ns_light, ew_light);
    end
    n_checks++;
    if ({walk_ns, walk_ew} !== 2'b00) begin
      n_fail++;
      $display("FAIL rst_walk: %b%b want 00", walk_ns, walk_ew);
    end
    n_checks++;
    if (phase !== 3'd0) begin
      n_fail++;
      $display("FAIL rst_phase: %0d want 0", phase);
    end
    n_checks++;
    if ({pend_ns, pend_ew} !== 2'b00) begin
      n_fail++;
      $display("FAIL rst_pend: %b%b want 00", pend_ns, pend_ew);
    end
    rst = 1'b0;
    tcnt = 2'd0;
  endtask

  task automatic test_free_run();
    logic [2:0] exp_ph [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
    logic [2:0] exp_ns [6] = '{3'b100, 3'b001, 3'b010,
                               3'b100, 3'b100, 3'b100};
    logic [2:0] exp_ew [6] = '{3'b100, 3'b100, 3'b100,
                               3'b100, 3'b001, 3'b010};
    int exp_dw [6] = '{1, 5, 2, 1, 5, 2};
    int n;
    int g;
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (phase !== exp_ph[i]) begin
        n_fail++;
        $display("FAIL free_phase: %0d want %0d", phase, exp_ph[i]);
      end
      n_checks++;
      if (ns_light !== exp_ns[i] || ew_light !== exp_ew[i]) begin
        n_fail++;
        $display("FAIL free_lights: ph %0d got %b %b want %b %b",
                 exp_ph[i], ns_light, ew_light, exp_ns[i], exp_ew[i]);
      end
      n = 0;
      g = 0;
      while (phase === exp_ph[i] && g < 200) begin
        cyc();
        g++;
        if (tick) n++;
        n_checks++;
        if (!$onehot(ns_light) || !$onehot(ew_light)) begin
          n_fail++;
          $display("FAIL onehot: %b %b want one-hot",
                   ns_light, ew_light);
        end
        n_checks++;
        if (walk_ns !== (phase == 3'd1) ||
            walk_ew !== (phase == 3'd4)) begin
          n_fail++;
          $display("FAIL walk: ph %0d got %b%b", phase,
                   walk_ns, walk_ew);
        end
      end
      n_checks++;
      if (n !== exp_dw[i]) begin
        n_fail++;
        $display("FAIL free_dwell: ph %0d got %0d ticks want %0d",
                 exp_ph[i], n, exp_dw[i]);
      end
    end
    n_checks++;
    if (phase !== 3'd0) begin
      n_fail++;
      $display("FAIL free_wrap: %0d want 0", phase);
    end
  endtask

  task automatic test_early_cut();
    int n;
    run_to(3'd4, "cut_reach4");
    ped_req_ns = 1'b1;
    cyc();
    ped_req_ns = 1'b0;
    n_checks++;
    if (pend_ns !== 1'b1 || phase !== 3'd4) begin
      n_fail++;
      $display("FAIL cut_pend: pend %b ph %0d want 1 4",
               pend_ns, phase);
    end
    dwell(n);
    n_checks++;
    if (n !== 2 || phase !== 3'd5) begin
      n_fail++;
      $display("FAIL cut_ew: %0d ticks ph %0d want 2 5", n, phase);
    end
    run_to(3'd0, "cut_reach0");
    n_checks++;
    if (pend_ns !== 1'b1) begin
      n_fail++;
      $display("FAIL cut_keep: pend_ns %b want 1", pend_ns);
    end
    run_to(3'd1, "cut_reach1");
    n_checks++;
    if (pend_ns !== 1'b0 || walk_ns !== 1'b1) begin
      n_fail++;
      $display("FAIL cut_clear: pend %b walk %b want 0 1",
               pend_ns, walk_ns);
    end
  endtask

  task automatic test_drop_on_entry();
    int n;
    int g;
    run_to(3'd3, "drop_reach3");
    g = 0;
    while (tcnt != 2'd3 && g < 8) begin
      cyc();
      g++;
    end
    ped_req_ew = 1'b1;
    cyc();
    cyc();
    ped_req_ew = 1'b0;
    n_checks++;
    if (phase !== 3'd4 || pend_ew !== 1'b0) begin
      n_fail++;
      $display("FAIL drop: ph %0d pend_ew %b want 4 0",
               phase, pend_ew);
    end
    run_to(3'd1, "drop_reach1");
    ped_req_ew = 1'b1;
    cyc();
    ped_req_ew = 1'b0;
    n_checks++;
    if (pend_ew !== 1'b1) begin
      n_fail++;
      $display("FAIL ew_latch: pend_ew %b want 1", pend_ew);
    end
    dwell(n);
    n_checks++;
    if (n !== 2 || phase !== 3'd2) begin
      n_fail++;
      $display("FAIL cut_ns: %0d ticks ph %0d want 2 2", n, phase);
    end
    run_to(3'd4, "drop_reach4");
    n_checks++;
    if (pend_ew !== 1'b0) begin
      n_fail++;
      $display("FAIL ew_clear: pend_ew %b want 0", pend_ew);
    end
  endtask

  task automatic test_async_reset();
    int n;
    run_to(3'd2, "ar_reach2");
    ped_req_ns = 1'b1;
    cyc();
    ped_req_ns = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({ns_light, ew_light, walk_ns, walk_ew} !== 8'b100_100_00) begin
      n_fail++;
      $display("FAIL ar_out: %b %b %b%b want 100 100 00",
               ns_light, ew_light, walk_ns, walk_ew);
    end
    n_checks++;
    if (phase !== 3'd0 || pend_ns !== 1'b0) begin
      n_fail++;
      $display("FAIL ar_state: ph %0d pend %b want 0 0",
               phase, pend_ns);
    end
    tick = 1'b0;
    @(posedge clk_in);
    #1;
    rst = 1'b0;
    tcnt = 2'd0;
    dwell(n);
    n_checks++;
    if (n !== 1 || phase !== 3'd1) begin
      n_fail++;
      $display("FAIL ar_restart: %0d ticks ph %0d want 1 1",
               n, phase);
    end
  endtask

  task automatic test_tick_hold();
    bit moved;
    repeat (4) cyc();
    n_checks++;
    if (phase !== 3'd1 || dut.u_timer.count !== 8'd1) begin
      n_fail++;
      $display("FAIL hold_pre: ph %0d tmr %0d want 1 1",
               phase, dut.u_timer.count);
    end
    tick_en = 1'b0;
    moved = 1'b0;
    repeat (100) begin
      cyc();
      if (phase !== 3'd1 || dut.u_timer.count !== 8'd1)
        moved = 1'b1;
    end
    n_checks++;
    if (moved) begin
      n_fail++;
      $display("FAIL hold_notick: ph %0d tmr %0d want 1 1",
               phase, dut.u_timer.count);
    end
    force dut.state_q = state_t'(3'd7);
    #1;
    n_checks++;
    if (phase !== 3'd7 || {ns_light, ew_light} !== 6'b100_100) begin
      n_fail++;
      $display("FAIL bad_decode: ph %0d %b %b want 7 100 100",
               phase, ns_light, ew_light);
    end
    cyc();
    release dut.state_q;
    cyc();
    n_checks++;
    if (phase !== 3'd0) begin
      n_fail++;
      $display("FAIL bad_recover: ph %0d want 0", phase);
    end
    tick_en = 1'b1;
    tcnt = 2'd0;
  endtask

`ifdef PREEMPT_EN
  task automatic test_preempt();
    int n;
    bit moved;
    run_to(3'd4, "pre_reach4");
    repeat (4) cyc();
    preempt = 1'b1;
    cyc();
    n_checks++;
    if (phase !== 3'd5) begin
      n_fail++;
      $display("FAIL pre_cut: ph %0d want 5", phase);
    end
    dwell(n);
    n_checks++;
    if (n !== 2 || phase !== 3'd0) begin
      n_fail++;
      $display("FAIL pre_yel: %0d ticks ph %0d want 2 0", n, phase);
    end
    moved = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      ped_req_ns = (i == 5);
      cyc();
      if (tick) n++;
      if (phase !== 3'd0 || dut.u_timer.count !== 8'd0)
        moved = 1'b1;
    end
    ped_req_ns = 1'b0;
    n_checks++;
    if (moved || n !== 10) begin
      n_fail++;
      $display("FAIL pre_hold: moved %b ticks %0d want 0 10",
               moved, n);
    end
    n_checks++;
    if (pend_ns !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_pend: pend_ns %b want 1", pend_ns);
    end
    preempt = 1'b0;
    dwell(n);
    n_checks++;
    if (n !== 1 || phase !== 3'd1) begin
      n_fail++;
      $display("FAIL pre_release: %0d ticks ph %0d want 1 1",
               n, phase);
    end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_free_run();
    test_early_cut();
    test_drop_on_entry();
    test_async_reset();
    test_tick_hold();
`ifdef PREEMPT_EN
    test_preempt();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
